// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller and its datapath:
// FSM states, opcodes, ALU operation codes and PC source select codes.
package multicycle_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_HALT   = 3'd5;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // Opcodes 9..E carry no operation.
  function automatic logic op_is_nop(input logic [3:0] op);
    return (op > OP_J) && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts cycles a memory request has been pending; expired_o flags the
// last allowed wait cycle so the FSM can fault out on the following edge.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for a small multicycle CPU: sequences fetch, decode, execute,
// memory and write-back, with a memory-wait timeout that parks in HALT.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       CLK_I,
  input  logic       RSTN_I,
  input  logic [3:0] OPCODE_I,
  input  logic       ZERO_I,
  input  logic       MEM_READY_I,
  output logic       PC_WE_O,
  output logic       IR_WE_O,
  output logic       MEM_RD_O,
  output logic       MEM_WR_O,
  output logic       IMM_SEL_O,
  output logic [2:0] ALU_OP_O,
  output logic [1:0] PC_SRC_O,
  output logic       REG_WE_O,
  output logic       HALT_O,
  output logic       FAULT_O,
  output logic [2:0] STATE_O
);

  state_t     state_q, state_d;
  logic [3:0] opc_q, opc_d;
  logic       fault_q, fault_d;
  logic       run_q;
  logic       mem_req, expired, timer_clr;

  // run_q holds FETCH quiet for the cycle in which reset is released.
  assign mem_req   = ((state_q == S_FETCH) && run_q) || (state_q == S_MEM);
  assign timer_clr = MEM_READY_I || (state_d != state_q);

  mem_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_wait (
    .clk_i     (CLK_I),
    .rst_ni    (RSTN_I),
    .clear_i   (timer_clr),
    .enable_i  (mem_req),
    .expired_o (expired)
  );

  always_comb begin
    PC_WE_O   = 1'b0;
    IR_WE_O   = 1'b0;
    MEM_RD_O  = 1'b0;
    MEM_WR_O  = 1'b0;
    IMM_SEL_O = 1'b0;
    ALU_OP_O  = ALU_ADD;
    PC_SRC_O  = PC_INC;
    REG_WE_O  = 1'b0;
    HALT_O    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          MEM_RD_O = 1'b1;
          IR_WE_O  = MEM_READY_I;
          PC_WE_O  = MEM_READY_I;
        end
      end
      S_EXEC: begin
        case (opc_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR: ALU_OP_O = opc_q[2:0];
          OP_ADDI, OP_LW, OP_SW:         IMM_SEL_O = 1'b1;
          OP_BEQ: begin
            ALU_OP_O = ALU_SUB;
            PC_SRC_O = PC_BRANCH;
            PC_WE_O  = ZERO_I;
          end
          OP_J: begin
            PC_SRC_O = PC_JUMP;
            PC_WE_O  = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        MEM_RD_O = (opc_q == OP_LW);
        MEM_WR_O = (opc_q == OP_SW);
      end
      S_WB:    REG_WE_O = 1'b1;
      S_HALT:  HALT_O   = 1'b1;
      default: ;
    endcase
  end

  assign FAULT_O = fault_q;
  assign STATE_O = state_q;

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    fault_d = fault_q;
    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          if (MEM_READY_I) begin
            state_d = S_DECODE;
          end else if (expired) begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end
        end
      end
      S_DECODE: begin
        opc_d = OPCODE_I;
        if (OPCODE_I == OP_HALT) begin
          state_d = S_HALT;
        end else if (op_is_nop(OPCODE_I)) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opc_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:                           state_d = S_MEM;
          default:                                state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (MEM_READY_I) begin
          state_d = (opc_q == OP_LW) ? S_WB : S_FETCH;
        end else if (expired) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
      fault_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      fault_q <= fault_d;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle queues the
// hand-computed output vector; a monitor pops and compares every cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       RSTN_I, ZERO_I, MEM_READY_I;
  logic [3:0] OPCODE_I;
  logic       PC_WE_O, IR_WE_O, MEM_RD_O, MEM_WR_O, IMM_SEL_O, REG_WE_O;
  logic       HALT_O, FAULT_O;
  logic [2:0] ALU_OP_O, STATE_O;
  logic [1:0] PC_SRC_O;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .MEM_TIMEOUT (15)
  ) dut (
    .CLK_I       (clk),
    .RSTN_I      (RSTN_I),
    .OPCODE_I    (OPCODE_I),
    .ZERO_I      (ZERO_I),
    .MEM_READY_I (MEM_READY_I),
    .PC_WE_O     (PC_WE_O),
    .IR_WE_O     (IR_WE_O),
    .MEM_RD_O    (MEM_RD_O),
    .MEM_WR_O    (MEM_WR_O),
    .IMM_SEL_O   (IMM_SEL_O),
    .ALU_OP_O    (ALU_OP_O),
    .PC_SRC_O    (PC_SRC_O),
    .REG_WE_O    (REG_WE_O),
    .HALT_O      (HALT_O),
    .FAULT_O     (FAULT_O),
    .STATE_O     (STATE_O)
  );

  // {state[2:0], halt, fault, rd, wr, ir_we, pc_we, pc_src[1:0], imm, alu[2:0], reg_we}
  localparam logic [15:0] S0 = 16'h0000, S1 = 16'h2000, S2 = 16'h4000;
  localparam logic [15:0] S3 = 16'h6000, S4 = 16'h8000, S5 = 16'hA000;
  localparam logic [15:0] HLT = 16'h1000, FLT = 16'h0800, RD = 16'h0400;
  localparam logic [15:0] WR = 16'h0200, IRW = 16'h0100, PCW = 16'h0080;
  localparam logic [15:0] SRC2 = 16'h0040, SRC1 = 16'h0020, IMM = 16'h0010;
  localparam logic [15:0] A1 = 16'h0002, A3 = 16'h0006, RWE = 16'h0001;
  localparam logic [15:0] FR = S0 | RD | IRW | PCW;

  logic [15:0] act;
  assign act = {STATE_O, HALT_O, FAULT_O, MEM_RD_O, MEM_WR_O, IR_WE_O, PC_WE_O,
                PC_SRC_O, IMM_SEL_O, ALU_OP_O, REG_WE_O};

  logic [15:0] exp_q[$];
  string       name_q[$];
  int unsigned n_run  = 0;
  int unsigned n_fail = 0;
  logic [15:0] mon_e;
  string       mon_nm;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      n_run++;
      if (act !== mon_e) begin
        n_fail++;
        $display("FAIL %s: outputs got %h expected %h", mon_nm, act, mon_e);
      end
    end
  end

  task automatic cyc(input logic r, input logic rdy, input logic z,
                     input logic [3:0] op, input logic [15:0] e, input string nm);
    RSTN_I      = r;
    MEM_READY_I = rdy;
    ZERO_I      = z;
    OPCODE_I    = op;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_seq(input string nm);
    cyc(1'b0, 1'b0, 1'b0, 4'hA, S0, {nm, "_rst"});
    cyc(1'b0, 1'b1, 1'b0, 4'hA, S0, {nm, "_rst_rdy"});
    cyc(1'b1, 1'b1, 1'b0, 4'hA, S0, {nm, "_release"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN_I = 1'b0; MEM_READY_I = 1'b0; ZERO_I = 1'b0; OPCODE_I = 4'h0;
    @(posedge clk);
    #1;
    reset_seq("init");

    // ADD with MEM_READY_I held high in non-memory states (must be ignored)
    cyc(1, 1, 0, 4'h0, FR,        "add_fetch");
    cyc(1, 1, 0, 4'h0, S1,        "add_dec");
    cyc(1, 1, 0, 4'h0, S2,        "add_exec");
    cyc(1, 1, 0, 4'h0, S4 | RWE,  "add_wb");
    cyc(1, 1, 0, 4'h3, FR,        "or_fetch");
    cyc(1, 0, 0, 4'h3, S1,        "or_dec");
    cyc(1, 0, 0, 4'h3, S2 | A3,   "or_exec");
    cyc(1, 0, 0, 4'h3, S4 | RWE,  "or_wb");
    cyc(1, 1, 0, 4'h4, FR,        "addi_fetch");
    cyc(1, 0, 0, 4'h4, S1,        "addi_dec");
    cyc(1, 0, 0, 4'h4, S2 | IMM,  "addi_exec");
    cyc(1, 0, 0, 4'h4, S4 | RWE,  "addi_wb");

    // LW, memory ready after 3 wait cycles
    cyc(1, 1, 0, 4'h5, FR,        "lw_fetch");
    cyc(1, 0, 0, 4'h5, S1,        "lw_dec");
    cyc(1, 0, 0, 4'h5, S2 | IMM,  "lw_exec");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 4'h5, S3 | RD, "lw_mem_wait");
    cyc(1, 1, 0, 4'h5, S3 | RD,   "lw_mem_rdy");
    cyc(1, 0, 0, 4'h5, S4 | RWE,  "lw_wb");

    cyc(1, 1, 0, 4'h6, FR,        "sw_fetch");
    cyc(1, 0, 0, 4'h6, S1,        "sw_dec");
    cyc(1, 0, 0, 4'h6, S2 | IMM,  "sw_exec");
    cyc(1, 1, 0, 4'h6, S3 | WR,   "sw_mem");

    cyc(1, 1, 1, 4'h7, FR,                    "beq1_fetch");
    cyc(1, 0, 1, 4'h7, S1,                    "beq1_dec");
    cyc(1, 0, 1, 4'h7, S2 | A1 | SRC1 | PCW,  "beq1_exec");
    cyc(1, 1, 0, 4'h7, FR,                    "beq0_fetch");
    cyc(1, 0, 0, 4'h7, S1,                    "beq0_dec");
    cyc(1, 0, 0, 4'h7, S2 | A1 | SRC1,        "beq0_exec");

    cyc(1, 1, 0, 4'h8, FR,                 "j_fetch");
    cyc(1, 0, 0, 4'h8, S1,                 "j_dec");
    cyc(1, 0, 0, 4'h8, S2 | SRC2 | PCW,    "j_exec");

    cyc(1, 1, 0, 4'hA, FR, "nop_fetch");
    cyc(1, 0, 0, 4'hA, S1, "nop_dec");

    // Ready arriving on the final allowed wait cycle wins over the timeout
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 4'hA, S0 | RD, "late_wait");
    cyc(1, 1, 0, 4'hA, FR, "late_rdy");
    cyc(1, 0, 0, 4'hA, S1, "late_dec");

    // Reset during SW memory phase
    cyc(1, 1, 0, 4'h6, FR,        "swr_fetch");
    cyc(1, 0, 0, 4'h6, S1,        "swr_dec");
    cyc(1, 0, 0, 4'h6, S2 | IMM,  "swr_exec");
    cyc(1, 0, 0, 4'h6, S3 | WR,   "swr_mem");
    reset_seq("swr");
    cyc(1, 0, 0, 4'hA, S0 | RD,   "swr_refetch");
    cyc(1, 1, 0, 4'hA, FR,        "swr_refetch_rdy");
    cyc(1, 0, 0, 4'hA, S1,        "swr_dec2");

    // HALT opcode: halted from the third cycle, no fault, absorbing
    cyc(1, 1, 0, 4'hF, FR, "halt_fetch");
    cyc(1, 0, 0, 4'hF, S1, "halt_dec");
    for (int i = 0; i < 3; i++) cyc(1, i[0], 1, 4'h7, S5 | HLT, "halt_stay");
    reset_seq("halt");

    // Memory never ready in FETCH: timeout fault
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 4'h0, S0 | RD, "to_wait");
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 4'h8, S5 | HLT | FLT, "to_halted");
    reset_seq("to");
    cyc(1, 0, 0, 4'h0, S0 | RD, "to_refetch");

    @(negedge clk);
    #1;
    n_run++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending entries got %0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum wait cycles for MEM_READY_I before the fault stop.
REQ-002 CLK_I  input  1  sole clock; all state updates on its rising edge.
REQ-003 RSTN_I  input  1  reset; asynchronous, active-low.
REQ-004 OPCODE_I  input  4  instruction opcode; valid from the cycle after IR_WE_O is high.
REQ-005 ZERO_I  input  1  ALU zero flag; sampled in EXEC.
REQ-006 MEM_READY_I  input  1  memory handshake done.
REQ-007 PC_WE_O  output  1  PC write enable.
REQ-008 IR_WE_O  output  1  instruction register load.
REQ-009 MEM_RD_O / MEM_WR_O  output  1 each  memory read/write request.
REQ-010 IMM_SEL_O  output  1  ALU operand B = 6-bit sign-extended 4-bit immediate (1) or register (0).
REQ-011 ALU_OP_O  output  3  0 ADD, 1 SUB, 2 AND, 3 OR.
REQ-012 PC_SRC_O  output  2  0 PC+1, 1 branch target, 2 jump target.
REQ-013 REG_WE_O  output  1  register-file write enable.
REQ-014 HALT_O / FAULT_O  output  1 each  halted / halted by timeout.
REQ-015 STATE_O  output  3  current state encoding, for debug.

Function
REQ-016 The block SHALL have six states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-017 The opcode map SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LW, 6 SW, 7 BEQ, 8 J, F HALT; all others SHALL be NOP.
REQ-018 FETCH SHALL assert MEM_RD_O and hold it until MEM_READY_I is high.
REQ-019 In the cycle where FETCH sees MEM_READY_I high, the block SHALL assert IR_WE_O and PC_WE_O (PC_SRC_O=0) and go to DECODE.
REQ-020 DECODE SHALL latch OPCODE_I into an internal register.
REQ-021 From DECODE, HALT opcodes SHALL go to HALT, NOP opcodes SHALL go to FETCH, and all others SHALL go to EXEC.
REQ-022 In EXEC, R-type opcodes (0-3) SHALL drive ALU_OP_O = opcode with IMM_SEL_O=0, then go to WB.
REQ-023 In EXEC, ADDI SHALL drive ALU_OP_O=0 with IMM_SEL_O=1, then go to WB.
REQ-024 In EXEC, LW and SW SHALL drive ALU_OP_O=0 with IMM_SEL_O=1, then go to MEM.
REQ-025 In EXEC, BEQ SHALL drive ALU_OP_O=1, assert PC_WE_O with PC_SRC_O=1 only if ZERO_I=1, then go to FETCH.
REQ-026 In EXEC, J SHALL assert PC_WE_O with PC_SRC_O=2, then go to FETCH.
REQ-027 MEM SHALL hold MEM_RD_O (LW) or MEM_WR_O (SW) until MEM_READY_I; LW SHALL then go to WB and SW to FETCH.
REQ-028 WB SHALL assert REG_WE_O for exactly one cycle, then go to FETCH.
REQ-029 Cycle counts from FETCH entry to next FETCH, with zero-wait memory, SHALL be: R/ADDI 4, LW 5, SW 4, BEQ/J 3, NOP 2.
REQ-030 A wait counter SHALL count cycles spent with a memory request pending.
REQ-031 The wait counter SHALL clear on MEM_READY_I and on every state change.
REQ-032 When the wait counter reaches MEM_TIMEOUT without MEM_READY_I, the block SHALL go to HALT and set FAULT_O.
REQ-033 MEM_READY_I arriving on the timeout cycle SHALL win: normal transition, no fault.
REQ-034 HALT SHALL be absorbing, with HALT_O=1 and all enables 0; only reset exits it.
REQ-035 MEM_READY_I outside FETCH or MEM SHALL be ignored.
REQ-036 At most one of MEM_RD_O and MEM_WR_O SHALL be high in any cycle.
REQ-037 All outputs SHALL be decoded from the registered state and latched opcode only; the block SHALL have no combinational input-to-output path other than ZERO_I/MEM_READY_I gating of PC_WE_O and IR_WE_O.

Reset
REQ-038 RSTN_I low SHALL immediately force state FETCH, clear the latched opcode and wait counter, and clear FAULT_O; all outputs SHALL read 0.
REQ-039 Reset mid-operation SHALL abandon the current instruction without emitting REG_WE_O or PC_WE_O.
REQ-040 The first MEM_RD_O SHALL rise in the first cycle after RSTN_I deasserts.

Structure
REQ-041 A shared package SHALL hold the state encodings, the opcode constants, the ALU_OP codes and the PC_SRC codes, for reuse by the datapath.
REQ-042 The wait counter SHALL be a sub-module, mem_wait_timer, with inputs clear and enable and output expired.

Verification
REQ-043 ADD with zero-wait memory -> FETCH,DECODE,EXEC,WB; REG_WE_O high in cycle 4; ALU_OP_O=0, IMM_SEL_O=0 in EXEC.
REQ-044 LW with MEM_READY_I delayed 3 cycles in MEM -> MEM_RD_O held 4 cycles, then one REG_WE_O pulse; total 8 cycles.
REQ-045 BEQ with ZERO_I=1, then BEQ with ZERO_I=0 -> PC_WE_O with PC_SRC_O=1 only in the first; each takes 3 cycles.
REQ-046 MEM_READY_I never asserted in FETCH -> HALT after 15 wait cycles with FAULT_O=1, HALT_O=1; stays halted.
REQ-047 RSTN_I pulsed low during the MEM state of SW -> outputs go to 0 immediately; MEM_WR_O does not reappear; FETCH restarts after release.
REQ-048 Opcode F -> HALT_O=1 from cycle 3 with FAULT_O=0; opcode A -> NOP returning to FETCH after 2 cycles.
